// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, the default writable memory size and
// the NOP instruction word reserved for gating instruction fetch.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int          MEM_BYTES_DEF = 1024;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and byte-wide memory write port of the boot loader.
// master drives the stream and observes the write port; slave is the loader.
interface imem_boot_loader_if #(
  parameter int AW = 32
);

  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_load_validate.sv
// Combinational check of a load request: nonzero length, word-aligned base
// and length, and the whole image inside the writable memory window.
// The end address is formed one bit wider so base+length cannot wrap.
module imem_load_validate #(
  parameter int AW        = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW-1:0] length_i,
  output logic          req_ok_o
);

  logic [AW:0] end_addr;

  assign end_addr = {1'b0, base_addr_i} + {1'b0, length_i};

  assign req_ok_o = (length_i != '0)
                 && (base_addr_i[1:0] == 2'b00)
                 && (length_i[1:0] == 2'b00)
                 && (end_addr <= (AW+1)'(MEM_BYTES));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory, then releases the core.
// Latency: each accepted byte is written one cycle later; core reset is
// released RST_HOLD cycles after the final write. s_ready is high only in LOAD.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int RST_HOLD  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       length,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          checksum
);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    hold_q, hold_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic req_ok;
  logic accept;

  imem_load_validate #(
    .AW        (AW),
    .MEM_BYTES (MEM_BYTES)
  ) u_validate (
    .base_addr_i (base_addr),
    .length_i    (length),
    .req_ok_o    (req_ok)
  );

  assign bus.s_ready   = (state_q == LOAD);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign checksum      = csum_q;

  // abort in the same cycle as a handshake discards the byte
  assign accept = bus.s_valid && (state_q == LOAD) && !abort;

  // next-state, counters and the registered write strobe
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    count_d     = count_q;
    csum_d      = csum_q;
    hold_d      = hold_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_ok) begin
            state_d     = LOAD;
            base_d      = base_addr;
            len_d       = length;
            count_d     = '0;
            csum_d      = '0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            cpu_rst_n_d = 1'b0;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d     = IDLE;
          error_d     = 1'b1;
          done_d      = 1'b0;
          cpu_rst_n_d = 1'b0;
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = base_q + count_q;
          wdata_d = bus.s_data;
          csum_d  = csum_q + bus.s_data;
          count_d = count_q + AW'(1);
          if (count_q == len_q - AW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // the final write is already registered and completes regardless
        if (abort) begin
          state_d     = IDLE;
          error_d     = 1'b1;
          done_d      = 1'b0;
          cpu_rst_n_d = 1'b0;
        end else begin
          hold_d  = 8'(RST_HOLD);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d     = IDLE;
          error_d     = 1'b1;
          done_d      = 1'b0;
          cpu_rst_n_d = 1'b0;
        end else begin
          hold_d = hold_q - 8'd1;
          if (hold_q == 8'd1) begin
            state_d     = IDLE;
            cpu_rst_n_d = 1'b1;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      csum_q      <= '0;
      hold_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
      hold_q      <= hold_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios followed by
// randomized requests, compared against a behavioural model of the load.
module tb_imem_boot_loader;

  localparam int AW   = 32;
  localparam int MEMB = 1024;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] length = '0;
  logic        cpu_rst_n, busy, done, error;
  logic [7:0]  checksum;

  imem_boot_loader_if #(.AW(AW)) bus ();

  imem_boot_loader #(
    .AW        (AW),
    .MEM_BYTES (MEMB),
    .RST_HOLD  (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  bit m_run    = 1'b0;   // model: core out of reset

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) wr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit vpat(input int mode, input int cyc);
    logic [6:0] p;
    p = 7'b1001101;   // 1,0,0,1,1,0,1 from MSB
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return p[6 - (cyc % 7)];
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_run = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic start_req(input logic [31:0] b, input logic [31:0] l, input bit ab);
    start = 1'b1; base_addr = b; length = l; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic bad_req(input logic [31:0] b, input logic [31:0] l, input string tag);
    int w0;
    bit saw;
    w0 = wr_cnt; saw = 1'b0;
    start_req(b, l, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.s_ready || bus.mem_we || busy) saw = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_error"}, error, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_quiet"}, saw, 0);
    check({tag, "_writes"}, wr_cnt - w0, 0);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, m_run);
  endtask

  task automatic run_load(input logic [31:0] b, input int n, input int vmode, input bit seq,
                          input int abort_at, input int start_at, input bit rst_hold,
                          input string tag);
    logic [7:0] bytes [256];
    logic [7:0] sum;
    int idx, cyc, w0, low;
    bit prev, acc, ab, rel, hold_we;
    for (int i = 0; i < n; i++) bytes[i] = seq ? 8'(i + 1) : 8'($urandom);
    w0 = wr_cnt; sum = '0; idx = 0; cyc = 0; prev = 1'b0; ab = 1'b0;
    start_req(b, n, (vmode == 1) && ($urandom_range(0, 2) == 0));
    while (idx < n && cyc < 600) begin
      bus.s_valid = vpat(vmode, cyc) || (idx == abort_at);
      bus.s_data  = bytes[idx];
      abort       = (idx == abort_at);
      start       = (cyc == start_at);
      base_addr   = 32'h300;
      length      = 32'd8;
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_cpu_held"}, cpu_rst_n, 0);
      end
      if (prev) begin
        check({tag, "_we"}, bus.mem_we, 1);
        check({tag, "_addr"}, bus.mem_addr, b + idx - 1);
        check({tag, "_wdata"}, bus.mem_wdata, bytes[idx-1]);
      end else begin
        check({tag, "_we_idle"}, bus.mem_we, 0);
      end
      acc = bus.s_valid && bus.s_ready && !abort;
      ab  = abort;
      @(posedge clk); #1;
      prev = acc;
      if (acc) begin
        sum = sum + bytes[idx];
        idx++;
      end
      cyc++;
      if (ab) break;
    end
    bus.s_valid = 1'b0; abort = 1'b0; start = 1'b0;

    if (ab) begin
      @(negedge clk);
      check({tag, "_ab_we"}, bus.mem_we, 0);
      check({tag, "_ab_busy"}, busy, 0);
      check({tag, "_ab_error"}, error, 1);
      check({tag, "_ab_done"}, done, 0);
      check({tag, "_ab_cpu"}, cpu_rst_n, 0);
      check({tag, "_ab_checksum"}, checksum, sum);
      check({tag, "_ab_writes"}, wr_cnt - w0, abort_at);
      m_run = 1'b0;
      @(posedge clk); #1;
      return;
    end

    check({tag, "_stream_done"}, idx, n);
    @(negedge clk);
    check({tag, "_drain_we"}, bus.mem_we, 1);
    check({tag, "_drain_addr"}, bus.mem_addr, b + n - 1);
    check({tag, "_drain_wdata"}, bus.mem_wdata, bytes[n-1]);
    check({tag, "_drain_ready"}, bus.s_ready, 0);
    low = 0; rel = 1'b0; hold_we = 1'b0;
    for (int k = 0; k < 40 && !rel; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (cpu_rst_n) begin
        rel = 1'b1;
      end else begin
        low++;
        if (bus.mem_we) hold_we = 1'b1;
        if (rst_hold && low == 2) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          @(negedge clk);
          check_reset_outputs({tag, "_rst"});
          rst_n = 1'b1;
          m_run = 1'b0;
          @(posedge clk); #1;
          return;
        end
      end
    end
    check({tag, "_hold_cycles"}, low, HOLD);
    check({tag, "_hold_we"}, hold_we, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_checksum"}, checksum, sum);
    check({tag, "_writes"}, wr_cnt - w0, n);
    m_run = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rb, rl;
    int ra;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // known image 01..08, checksum 0x24
    run_load(32'h10, 8, 0, 1'b1, -1, -1, 1'b0, "seq8");
    check("seq8_sum_value", checksum, 8'h24);

    bad_req(32'h2, 32'd4, "misalign");
    bad_req(32'h0, 32'd0, "zero_len");
    bad_req(32'h3FC, 32'd8, "out_of_range");

    run_load(32'h40, 4, 2, 1'b0, -1, -1, 1'b0, "throttle");
    run_load(32'h80, 8, 0, 1'b0, 2, -1, 1'b0, "abort");
    run_load(32'h100, 8, 0, 1'b0, -1, 2, 1'b1, "midhold");
    run_load(32'(MEMB - 16), 16, 1, 1'b0, -1, -1, 1'b0, "top_edge");

    for (int it = 0; it < 14; it++) begin
      rb = $urandom_range(0, 1100);
      rl = $urandom_range(0, 80);
      if ($urandom_range(0, 3) != 0) begin
        rb[1:0] = 2'b00;
        rl[1:0] = 2'b00;
      end
      if (rl != 0 && rb % 4 == 0 && rl % 4 == 0 && longint'(rb) + longint'(rl) <= longint'(MEMB)) begin
        ra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
        run_load(rb, int'(rl), int'($urandom_range(0, 2)), 1'b0, ra, -1, 1'b0, "rnd");
      end else begin
        bad_req(rb, rl, "rnd_bad");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program load into the byte-wide, big-endian instruction memory. At base+n it holds bits 31:24, at base+n+1 it holds bits 23:16, and so on.
- Accepts a byte stream over a valid/ready handshake and converts it into registered single-byte write strobes for the memory write port.
- Holds the single-cycle core in reset until a complete, valid image has been written, then releases it.
- Sits between the UART/debug byte source, the instruction memory write port and the core reset input.

Parameters:
- AW, 32, width of the address and length fields.
- MEM_BYTES, 1024, number of writable bytes; valid addresses are 0..MEM_BYTES-1.
- RST_HOLD, 4, cycles cpu_rst_n stays low after the final byte is written (range 1..255).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- abort  input  1  cancels an in-progress load.
- base_addr  input  AW  first byte address; sampled on start.
- length  input  AW  number of bytes to load; sampled on start.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  byte-stream ready.
- mem_we  output  1  memory byte write enable.
- mem_addr  output  AW  memory byte write address.
- mem_wdata  output  8  memory byte write data.
- cpu_rst_n  output  1  core reset, active-low.
- busy  output  1  high while in LOAD, DRAIN or HOLD.
- done  output  1  sticky; last load completed successfully.
- error  output  1  sticky; last start was rejected or the load was aborted.
- checksum  output  8  modulo-256 sum of the bytes accepted in the current/last load.

Behaviour:
- Reset values (rst_n low at a clock edge):
  - state=IDLE.
  - s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst_n=0, busy=0, done=0, error=0, checksum=0.
  - Internal counters are cleared.
  - The core stays in reset until the first successful load.
- States:
  - IDLE: s_ready=0. On start, validate the request:
    - valid if length!=0, base_addr[1:0]==0, length[1:0]==0 and base_addr+length<=MEM_BYTES;
    - compute the sum with AW+1 bits so it cannot overflow.
  - IDLE, start and valid: go to LOAD; latch base/length; clear count, checksum, done and error; drive cpu_rst_n=0.
  - IDLE, start and invalid: stay in IDLE; error=1, done=0; cpu_rst_n unchanged.
  - LOAD: s_ready=1.
    - A byte is accepted when s_valid && s_ready.
    - On accept, the next cycle has mem_we=1, mem_addr=base+count, mem_wdata=s_data. The write is registered, giving a 1-cycle latency.
    - On accept, checksum+=s_data (mod 256) and count++.
    - When the accepted byte is number length-1 (count==length-1), go to DRAIN. s_ready drops in that same following cycle.
  - DRAIN: exactly one cycle.
    - The final mem_we pulse is asserted here.
    - s_ready=0.
    - Load the hold counter with RST_HOLD and go to HOLD.
  - HOLD: mem_we=0 and cpu_rst_n=0; decrement the hold counter each cycle. When it reaches 0: cpu_rst_n=1, done=1, busy=0, go to IDLE.
- mem_we is high for exactly one cycle per accepted byte and low in every other cycle. mem_addr/mem_wdata hold their last values while mem_we=0.
- Back-to-back accepts give one byte per cycle; s_valid may drop at any time without loss.
- start while busy is ignored.
- abort:
  - In LOAD, DRAIN or HOLD: go to IDLE next cycle; error=1, done=0, cpu_rst_n=0.
  - In DRAIN, the pending write still completes.
  - In IDLE, abort is ignored.
- abort and an accept in the same LOAD cycle: abort wins. The byte is not counted and not written, and checksum is unchanged.
- start and abort in the same IDLE cycle: start is processed and abort is ignored.
- rst_n low in any state returns all outputs to their reset values on that edge; a partial image is left as-is in memory.
- A successful re-load from IDLE while cpu_rst_n=1 pulls cpu_rst_n low on the start-accept edge.

Decomposition:
- Shared package (imem_pkg):
  - state encoding enum: IDLE, LOAD, DRAIN, HOLD;
  - MEM_BYTES default;
  - NOP word constant 32'h00000013, reserved for the fetch-gating follow-on.
- One natural sub-module: imem_load_validate, a combinational request checker (alignment, nonzero length, bounds) returning req_ok.
- Counters, FSM and write register stay in imem_boot_loader.

Test Plan:
- Reset then idle for 10 cycles -> cpu_rst_n=0, s_ready=0, mem_we=0, done=0, error=0.
- Successful load:
  - stimulus: start with base=0x10, length=8; stream bytes 01..08 back-to-back;
  - expected writes: mem_we pulses at addresses 0x10..0x17 with data 01..08, each one cycle after its accept;
  - expected completion: checksum=0x24; cpu_rst_n rises 4 cycles after the DRAIN cycle; done=1.
- Illegal requests are rejected:
  - the requests: base=0x02 with length=4; base=0 with length=0; base=0x3FC with length=8;
  - each gives error=1, stays in IDLE, and never asserts s_ready or mem_we.
- Throttled stream: length=4, s_valid toggling 1,0,0,1,1,0,1 -> exactly 4 mem_we pulses at consecutive addresses; no duplicate or lost byte.
- abort after 2 of 8 bytes, asserted in the same cycle as a third s_valid -> exactly 2 writes; checksum equals the sum of the first 2 bytes; error=1, done=0, cpu_rst_n=0.
- Reset mid-HOLD and start during LOAD:
  - rst_n low during HOLD -> all outputs at reset values the next cycle;
  - start pulsed during LOAD -> ignored; base and length unchanged.
